// File: rtl/adsr_envelope.sv
// adsr_envelope: attack/decay/sustain/release amplitude envelope applied to the mixed sample stream.
// State and level advance only on ticks; the output product uses the level held before the tick.
module adsr_envelope #(
    parameter int width_p     = 24,
    parameter int lvl_width_p = 16
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic signed [width_p-1:0] sample_i,
    input  logic                      sample_valid_i,
    input  logic                      gate_i,
    input  logic [lvl_width_p-1:0]    attack_step_i,
    input  logic [lvl_width_p-1:0]    decay_step_i,
    input  logic [lvl_width_p-1:0]    sustain_level_i,
    input  logic [lvl_width_p-1:0]    release_step_i,
    output logic signed [width_p-1:0] sample_o,
    output logic                      valid_o,
    output logic [2:0]                state_o,
    output logic                      busy_o,
    output logic [lvl_width_p-1:0]    level_o
);
    localparam int pw = width_p + lvl_width_p + 1;
    localparam logic [lvl_width_p-1:0] max_lvl = '1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_e;

    state_e                 state_q, state_n;
    logic [lvl_width_p-1:0] level_q, level_n;
    logic [lvl_width_p:0]   att_sum, dec_diff, rel_diff;
    logic                   att_full, dec_done, rel_done;
    logic signed [pw-1:0]   product;

    // Extra top bit on each difference flags an underflow instead of wrapping.
    assign att_sum  = {1'b0, level_q} + {1'b0, attack_step_i};
    assign dec_diff = {1'b0, level_q} - {1'b0, decay_step_i};
    assign rel_diff = {1'b0, level_q} - {1'b0, release_step_i};
    assign att_full = attack_step_i == '0 || att_sum >= {1'b0, max_lvl};
    assign dec_done = decay_step_i == '0 || dec_diff[lvl_width_p] || dec_diff <= {1'b0, sustain_level_i};
    assign rel_done = release_step_i == '0 || rel_diff[lvl_width_p] || rel_diff == '0;
    assign product  = pw'(sample_i) * pw'($signed({1'b0, level_q}));

    always_comb begin
        state_n = state_q;
        level_n = level_q;
        if (sample_valid_i) begin
            case (state_q)
                IDLE: begin
                    state_n = gate_i ? ATTACK : IDLE;
                    level_n = '0;
                end
                ATTACK: begin
                    state_n = !gate_i ? RELEASE : att_full ? DECAY : ATTACK;
                    level_n = !gate_i ? level_q : att_full ? max_lvl : att_sum[lvl_width_p-1:0];
                end
                DECAY: begin
                    state_n = !gate_i ? RELEASE : dec_done ? SUSTAIN : DECAY;
                    level_n = !gate_i ? level_q : dec_done ? sustain_level_i : dec_diff[lvl_width_p-1:0];
                end
                SUSTAIN: begin
                    state_n = !gate_i ? RELEASE : SUSTAIN;
                    level_n = !gate_i ? level_q : sustain_level_i;
                end
                RELEASE: begin
                    state_n = gate_i ? ATTACK : rel_done ? IDLE : RELEASE;
                    level_n = gate_i ? level_q : rel_done ? '0 : rel_diff[lvl_width_p-1:0];
                end
                default: begin
                    state_n = IDLE;
                    level_n = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            level_q  <= '0;
            sample_o <= '0;
            valid_o  <= 1'b0;
        end else begin
            state_q <= state_n;
            level_q <= level_n;
            valid_o <= sample_valid_i;
            if (sample_valid_i)
                sample_o <= width_p'(product >>> lvl_width_p);
        end
    end

    assign state_o = state_q;
    assign busy_o  = state_q != IDLE;
    assign level_o = level_q;
endmodule

// File: tb/tb_adsr_envelope.sv
// tb_adsr_envelope: table vectors, hand sequences and randomized ticks checked against an integer envelope model.
module tb_adsr_envelope;
    localparam int W    = 24;
    localparam int L    = 16;
    localparam int MAXL = (1 << L) - 1;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic [W-1:0]  sample_i = '0;
    logic          sample_valid_i = 1'b0;
    logic          gate_i = 1'b0;
    logic [L-1:0]  attack_step_i = '0, decay_step_i = '0, sustain_level_i = '0, release_step_i = '0;
    logic [W-1:0]  sample_o;
    logic          valid_o, busy_o;
    logic [2:0]    state_o;
    logic [L-1:0]  level_o;

    int            n_chk = 0, n_fail = 0;
    int            m_state = 0, m_lvl = 0;
    logic [W-1:0]  m_out = '0;
    bit            m_valid = 0;

    typedef struct {
        bit           v;
        bit           g;
        logic [W-1:0] s;
        int           st;
        int           lvl;
    } vec_t;

    always #5 clk = ~clk;

    adsr_envelope #(.width_p(W), .lvl_width_p(L)) dut (
        .clk_i(clk), .reset_i(reset_i), .sample_i(sample_i), .sample_valid_i(sample_valid_i),
        .gate_i(gate_i), .attack_step_i(attack_step_i), .decay_step_i(decay_step_i),
        .sustain_level_i(sustain_level_i), .release_step_i(release_step_i),
        .sample_o(sample_o), .valid_o(valid_o), .state_o(state_o), .busy_o(busy_o), .level_o(level_o)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Envelope rules in plain integer arithmetic: min/max clamps on the level.
    task automatic model_tick(input bit g, input logic [W-1:0] s);
        longint p;
        int a, d, su, r, nl;
        a = int'(attack_step_i); d = int'(decay_step_i);
        su = int'(sustain_level_i); r = int'(release_step_i);
        p = longint'($signed(s)) * m_lvl;
        m_out = W'(p >>> L);
        case (m_state)
            0: begin if (g) m_state = 1; m_lvl = 0; end
            1: if (!g) m_state = 4;
               else begin
                   nl = (a == 0 || m_lvl + a > MAXL) ? MAXL : m_lvl + a;
                   m_lvl = nl;
                   if (nl == MAXL) m_state = 2;
               end
            2: if (!g) m_state = 4;
               else begin
                   nl = (d == 0 || m_lvl - d < su) ? su : m_lvl - d;
                   m_lvl = nl;
                   if (nl == su) m_state = 3;
               end
            3: if (!g) m_state = 4; else m_lvl = su;
            default: if (g) m_state = 1;
               else begin
                   nl = (r == 0 || m_lvl - r < 0) ? 0 : m_lvl - r;
                   m_lvl = nl;
                   if (nl == 0) m_state = 0;
               end
        endcase
    endtask

    task automatic check_all(input string nm);
        chk({nm, ".state"}, 64'(state_o), 64'(m_state));
        chk({nm, ".level"}, 64'(level_o), 64'(m_lvl));
        chk({nm, ".valid"}, 64'(valid_o), 64'(m_valid));
        chk({nm, ".busy"}, 64'(busy_o), 64'(m_state != 0));
        chk({nm, ".sample"}, 64'(sample_o), 64'(m_out));
    endtask

    task automatic step(input bit v, input bit g, input logic [W-1:0] s, input string nm);
        sample_valid_i = v; gate_i = g; sample_i = s;
        @(posedge clk);
        if (v) model_tick(g, s);
        m_valid = v;
        #1;
        check_all(nm);
    endtask

    task automatic do_reset(input int n, input bit v, input string nm);
        reset_i = 1'b1; sample_valid_i = v; gate_i = 1'b1; sample_i = 24'h100000;
        repeat (n) @(posedge clk);
        m_state = 0; m_lvl = 0; m_out = '0; m_valid = 0;
        #1;
        reset_i = 1'b0;
        check_all(nm);
    endtask

    task automatic exp_sl(input string nm, input int st, input int lvl);
        chk({nm, ".st_k"}, 64'(state_o), 64'(st));
        chk({nm, ".lvl_k"}, 64'(level_o), 64'(lvl));
    endtask

    task automatic set_steps(input int a, input int d, input int su, input int r);
        attack_step_i = L'(a); decay_step_i = L'(d); sustain_level_i = L'(su); release_step_i = L'(r);
    endtask

    function automatic int rand_step();
        case ($urandom_range(0, 3))
            0:       return 0;
            1:       return int'($urandom_range(1, 255));
            default: return int'($urandom_range(1, MAXL));
        endcase
    endfunction

    initial begin
        vec_t adsr[12];
        bit   g_r;
        adsr = '{
            '{1, 1, 24'h100000, 1, 16'h0000}, '{1, 1, 24'h100000, 1, 16'h4000},
            '{1, 1, 24'h100000, 1, 16'h8000}, '{1, 1, 24'h100000, 1, 16'hC000},
            '{1, 1, 24'h100000, 2, 16'hFFFF}, '{1, 1, 24'h100000, 2, 16'hEFFF},
            '{1, 1, 24'h100000, 2, 16'hDFFF}, '{1, 1, 24'h100000, 2, 16'hCFFF},
            '{1, 1, 24'h100000, 3, 16'hC000}, '{1, 0, 24'h100000, 4, 16'hC000},
            '{1, 0, 24'h100000, 4, 16'h4000}, '{1, 0, 24'h100000, 0, 16'h0000}
        };

        do_reset(2, 0, "rst");
        exp_sl("rst", 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 24'h100000, "idle");
            chk("idle.sample_k", 64'(sample_o), 64'd0);
            chk("idle.valid_k", 64'(valid_o), 64'd1);
        end

        set_steps(16'h4000, 16'h1000, 16'hC000, 16'h8000);
        foreach (adsr[i]) begin
            step(adsr[i].v, adsr[i].g, adsr[i].s, "adsr");
            exp_sl("adsr", adsr[i].st, adsr[i].lvl);
        end

        set_steps(0, 0, 16'hFFFF, 0);
        step(1, 1, 24'h0, "scale_a");
        step(1, 1, 24'h0, "scale_b");
        step(1, 1, 24'h0, "scale_c");
        exp_sl("scale_c", 3, 16'hFFFF);
        step(1, 1, 24'h100000, "scale_pos");
        chk("scale_pos.k", 64'(sample_o), 64'(24'h0FFFF0));
        step(1, 1, 24'hF00000, "scale_neg");
        chk("scale_neg.k", 64'(sample_o), 64'(24'hF00010));
        do_reset(1, 0, "rst2");

        set_steps(16'h4000, 16'h1000, 16'hC000, 16'h8000);
        for (int i = 0; i < 7; i++) step(1, 1, 24'h012345, "retrig_up");
        exp_sl("retrig_dfff", 2, 16'hDFFF);
        step(1, 0, 24'h012345, "retrig_rel");
        exp_sl("retrig_rel", 4, 16'hDFFF);
        step(1, 0, 24'h012345, "retrig_rel2");
        exp_sl("retrig_rel2", 4, 16'h5FFF);
        step(1, 1, 24'h012345, "retrig_att");
        exp_sl("retrig_att", 1, 16'h5FFF);
        step(1, 1, 24'h012345, "retrig_att2");
        exp_sl("retrig_att2", 1, 16'h9FFF);
        do_reset(1, 0, "rst3");

        set_steps(0, 0, 16'h8000, 0);
        step(1, 1, 24'h7FFFFF, "zero_a");
        exp_sl("zero_a", 1, 0);
        step(1, 1, 24'h7FFFFF, "zero_d");
        exp_sl("zero_d", 2, 16'hFFFF);
        step(1, 1, 24'h7FFFFF, "zero_s");
        exp_sl("zero_s", 3, 16'h8000);
        step(1, 0, 24'h7FFFFF, "zero_r");
        exp_sl("zero_r", 4, 16'h8000);
        step(1, 0, 24'h7FFFFF, "zero_i");
        exp_sl("zero_i", 0, 0);

        step(1, 1, 24'h000010, "gap_a");
        step(1, 1, 24'h000010, "gap_d");
        step(1, 1, 24'h000010, "gap_s");
        step(0, 0, 24'h000020, "gap_off");
        exp_sl("gap_off", 3, 16'h8000);
        chk("gap_off.valid_k", 64'(valid_o), 64'd0);
        step(1, 1, 24'h000030, "gap_on");
        chk("gap_on.valid_k", 64'(valid_o), 64'd1);
        step(0, 0, 24'h000040, "gap_off2");
        do_reset(1, 1, "rst_tick");
        exp_sl("rst_tick", 0, 0);
        chk("rst_tick.valid_k", 64'(valid_o), 64'd0);

        g_r = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) == 0)
                set_steps(rand_step(), rand_step(), int'($urandom_range(0, MAXL)), rand_step());
            if ($urandom_range(0, 19) == 0) g_r = ~g_r;
            if ($urandom_range(0, 599) == 0) do_reset(1, 1'($urandom_range(0, 1)), "rnd_rst");
            else step($urandom_range(0, 3) != 0, g_r, W'($urandom), "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
